// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 raster timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int FRAME_W = 12;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic {
    ACTIVE_LOW  = 1'b0,
    ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  // Drive level of a sync pin for a given polarity and asserted state.
  function automatic logic sync_level(sync_pol_e pol, logic asserted);
    return asserted ? logic'(pol) : ~logic'(pol);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle handed from the timing generator to the pattern stage.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic               hsync;
  logic               vsync;
  logic               active;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame;

  modport master (
    output hsync, vsync, active, x, y, line_start, frame_start, frame
  );

  modport slave (
    input hsync, vsync, active, x, y, line_start, frame_start, frame
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               in_sync,
  output logic               in_active
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  generate
    if (TOTAL > (1 << COORD_W) || ACTIVE < 1 || SYNC < 1 || FP < 0 || BP < 0) begin : g_bad_params
      $error("vga_axis_counter: axis total %0d must fit %0d bits with ACTIVE, SYNC >= 1",
             TOTAL, COORD_W);
    end
  endgenerate

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] SYNC_LAST  = COORD_W'(ACTIVE + FP + SYNC - 1);

  assign wrap      = en && (count == LAST);
  assign in_sync   = (count >= SYNC_FIRST) && (count <= SYNC_LAST);
  assign in_active = (count < ACT_END);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator: axis counters, frame count, registered outputs.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int        H_ACTIVE  = H_ACTIVE_DEF,
  parameter int        H_FP      = H_FP_DEF,
  parameter int        H_SYNC    = H_SYNC_DEF,
  parameter int        H_BP      = H_BP_DEF,
  parameter int        V_ACTIVE  = V_ACTIVE_DEF,
  parameter int        V_FP      = V_FP_DEF,
  parameter int        V_SYNC    = V_SYNC_DEF,
  parameter int        V_BP      = V_BP_DEF,
  parameter sync_pol_e HSYNC_POL = ACTIVE_LOW,
  parameter sync_pol_e VSYNC_POL = ACTIVE_LOW
) (
  input  logic         clock,
  input  logic         reset,
  vga_timing_if.master vga
);

  logic [COORD_W-1:0] h_p0, v_p0;
  logic               h_wrap_p0, v_wrap_p0;
  logic               h_sync_p0, v_sync_p0;
  logic               h_act_p0, v_act_p0;
  logic [FRAME_W-1:0] frame_cnt;

  logic               hsync_p1, vsync_p1, active_p1;
  logic               line_start_p1, frame_start_p1;
  logic [COORD_W-1:0] x_p1, y_p1;
  logic [FRAME_W-1:0] frame_p1;

  // Stage p0: raster position counters
  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clock     (clock),
    .reset     (reset),
    .en        (1'b1),
    .count     (h_p0),
    .wrap      (h_wrap_p0),
    .in_sync   (h_sync_p0),
    .in_active (h_act_p0)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clock     (clock),
    .reset     (reset),
    .en        (h_wrap_p0),
    .count     (v_p0),
    .wrap      (v_wrap_p0),
    .in_sync   (v_sync_p0),
    .in_active (v_act_p0)
  );

  // Bumped on the joint wrap so the new count lands with the next frame_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (v_wrap_p0) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Stage p1: registered outputs describing the previous cycle's counter state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync_p1       <= sync_level(HSYNC_POL, 1'b0);
      vsync_p1       <= sync_level(VSYNC_POL, 1'b0);
      active_p1      <= 1'b0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      frame_p1       <= '0;
    end else begin
      hsync_p1       <= sync_level(HSYNC_POL, h_sync_p0);
      vsync_p1       <= sync_level(VSYNC_POL, v_sync_p0);
      active_p1      <= h_act_p0 && v_act_p0;
      line_start_p1  <= (h_p0 == '0);
      frame_start_p1 <= (h_p0 == '0) && (v_p0 == '0);
      x_p1           <= h_p0;
      y_p1           <= v_p0;
      frame_p1       <= frame_cnt;
    end
  end

  assign vga.hsync       = hsync_p1;
  assign vga.vsync       = vsync_p1;
  assign vga.active      = active_p1;
  assign vga.line_start  = line_start_p1;
  assign vga.frame_start = frame_start_p1;
  assign vga.x           = x_p1;
  assign vga.y           = y_p1;
  assign vga.frame       = frame_p1;

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for 640x480@60 Hz VGA with a 25.175 MHz pixel clock. It drives the pattern/colour stage directly downstream. Outputs are pixel coordinates, an active-video flag, sync pulses of the configured polarity, line/frame start strobes and a 12-bit frame counter. All outputs are registered, so the downstream stage needs no coordinate logic of its own.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks); line total H_T = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); frame total V_T = 525
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- clock  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock domain only
- hsync  out  1  horizontal sync at HSYNC_POL when asserted
- vsync  out  1  vertical sync at VSYNC_POL when asserted
- active  out  1  high while x < H_ACTIVE and y < V_ACTIVE
- x  out  10  horizontal counter value, 0..H_T-1
- y  out  10  vertical counter value, 0..V_T-1
- line_start  out  1  one-cycle pulse while x == 0
- frame_start  out  1  one-cycle pulse while x == 0 and y == 0
- frame  out  12  completed-frame count, modulo 4096

## Operation
- Internal counters h (0..H_T-1) and v (0..V_T-1).
  - h increments every clock and wraps to 0 after H_T-1.
  - v increments only when h wraps, and wraps to 0 after V_T-1.
- Hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751. It is deasserted otherwise.
- Vsync is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491. It is evaluated per line, independent of h.
- Frame counter:
  - frame increments by 1 on the joint wrap (h = H_T-1 and v = V_T-1).
  - 4095 wraps to 0.
  - The new value is visible in the same output cycle as the following frame_start.
- Output (x, y) is the raw counter value. It is never clipped or held during blanking; downstream gates on active.
- Reset values:
  - h = v = 0, x = y = 0, frame = 0.
  - active = 0, line_start = frame_start = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL (deasserted).
- Reset asserted mid-frame forces all of the above immediately (asynchronously). Counting restarts from h = v = 0 on the first rising edge after release.
- Parameter sums must fit 10 bits (H_T, V_T ≤ 1024). This is checked at elaboration.

## Timing
- Latency: one clock. All outputs in cycle n+1 describe counter state (h, v) of cycle n. Outputs are mutually aligned and glitch-free.
- First rising edge after reset release: outputs show x = 0, y = 0, active = 1, line_start = 1, frame_start = 1, frame = 0.
- Line period is exactly 800 clocks. Frame period is exactly 420 000 clocks.
- Relative to line_start:
  - hsync asserts 656 clocks after line_start and deasserts 752 clocks after line_start (duration 96).
  - active falls 640 clocks after line_start.
- Vsync asserts on the cycle x = 0, y = 490. It deasserts on the cycle x = 0, y = 492 (exactly 1600 clocks).
- frame changes only on cycles where frame_start = 1.

## Structure
- Package vga_timing_pkg:
  - default porch/sync/active constants for 640x480@60;
  - width constants COORD_W = 10, FRAME_W = 12;
  - a polarity enum (ACTIVE_LOW, ACTIVE_HIGH).
- Sub-module vga_axis_counter, instantiated twice (horizontal with enable tied high, vertical with enable = horizontal wrap).
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Outputs: count, wrap, in_sync, in_active.
- The top level combines the two instances, registers outputs and holds the frame counter.

## Test plan
- Reset held, then released: before the first edge, hsync = vsync = 1, active = 0, x = y = 0, frame = 0. After the first edge, frame_start = 1, line_start = 1, active = 1, x = 0.
- Free-run one line: active high for exactly 640 cycles. Hsync low for exactly 96 cycles starting at x = 656. line_start repeats every 800 cycles. x reaches 799, then 0 with y incremented.
- Free-run one frame: vsync low exactly for y = 490..491 (1600 cycles). Second frame_start 420 000 cycles after the first, with frame = 1. active never high for y ≥ 480.
- Frame wrap: run 4096 frames, or force the counter to 4095 through a bench hook. The next frame_start shows frame = 0.
- Reset pulse asserted asynchronously at x = 300, y = 200 for 3 cycles: outputs return to reset values without waiting for a clock edge. The first edge after release gives x = 0, y = 0, frame_start = 1, frame = 0.
- Override parameters to H_ACTIVE = 8, H_FP = 1, H_SYNC = 2, H_BP = 1, V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1, HSYNC_POL = 1: line period is 12, frame period is 84, and hsync is high for x = 9..10.
